// File: rtl/debounce_arbiter_if.sv
// Change-event handshake between the debouncer (master) and the panel/keypad controller (slave).
// Holds one pending event: channel number and new level, qualified by valid/ready.
interface debounce_arbiter_if #(
  parameter int N_CH = 4
);
  localparam int CH_W = $clog2(N_CH);

  logic            o_evt_valid;
  logic [CH_W-1:0] o_evt_ch;
  logic            o_evt_level;
  logic            i_evt_ready;

  modport master (
    output o_evt_valid,
    output o_evt_ch,
    output o_evt_level,
    input  i_evt_ready
  );

  modport slave (
    input  o_evt_valid,
    input  o_evt_ch,
    input  o_evt_level,
    output i_evt_ready
  );
endinterface

// File: rtl/debounce_arbiter.sv
// Multi-channel switch debouncer: one stability counter shared round-robin across N_CH inputs.
// Optional DEBOUNCE_ABORT_CNT_EN adds o_abort_cnt, a saturating count of aborted windows.
module debounce_arbiter #(
  parameter int N_CH     = 4,
  parameter int N_BOUNCE = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_CH-1:0]         i_sig,
  output logic [N_CH-1:0]         o_sig_debounced,
  output logic                    o_busy,
  output logic [$clog2(N_CH)-1:0] o_grant_id,
  debounce_arbiter_if.master      evt
`ifdef DEBOUNCE_ABORT_CNT_EN
  ,
  output logic [7:0]              o_abort_cnt
`endif
);
  localparam int CH_W = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

  state_t                state_reg, state_next;
  logic [N_CH-1:0]       sync1_reg, sync2_reg;
  logic [N_CH-1:0]       deb_reg, deb_next;
  logic [N_BOUNCE-1:0]   cnt_reg, cnt_next;
  logic [CH_W-1:0]       grant_reg, grant_next;
  logic [CH_W-1:0]       ptr_reg, ptr_next;
  logic                  evt_valid_reg, evt_valid_next;
  logic [CH_W-1:0]       evt_ch_reg, evt_ch_next;
  logic                  evt_level_reg, evt_level_next;
  logic [N_CH-1:0]       req;
  logic                  found;
  logic [CH_W-1:0]       pick;
  logic [CH_W-1:0]       grant_inc;
  logic                  bounce;
  int                    rr_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= i_sig;
      sync2_reg <= sync1_reg;
    end
  end

  // A channel wants the counter whenever its synchronised input disagrees with its debounced level.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_req
      assign req[gi] = sync2_reg[gi] ^ deb_reg[gi];
    end
  endgenerate

  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int i = 0; i < N_CH; i++) begin
      rr_idx = int'(ptr_reg) + i;
      if (rr_idx >= N_CH) rr_idx = rr_idx - N_CH;
      if (!found && req[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx[CH_W-1:0];
      end
    end
  end

  assign grant_inc = (grant_reg == CH_W'(N_CH - 1)) ? '0 : grant_reg + 1'b1;
  assign bounce    = (sync2_reg[grant_reg] == deb_reg[grant_reg]);

  always_comb begin
    state_next     = state_reg;
    deb_next       = deb_reg;
    cnt_next       = cnt_reg;
    grant_next     = grant_reg;
    ptr_next       = ptr_reg;
    evt_valid_next = evt_valid_reg && !evt.i_evt_ready;
    evt_ch_next    = evt_ch_reg;
    evt_level_next = evt_level_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          cnt_next   = '0;
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (bounce) begin
          state_next = IDLE;
          ptr_next   = grant_inc;
        end else if (cnt_reg == {N_BOUNCE{1'b1}}) begin
          state_next = COMMIT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      COMMIT: begin
        // Level only flips once the event slot can take it, so level and event stay in step.
        if (!evt_valid_reg || evt.i_evt_ready) begin
          deb_next[grant_reg] = ~deb_reg[grant_reg];
          evt_valid_next      = 1'b1;
          evt_ch_next         = grant_reg;
          evt_level_next      = ~deb_reg[grant_reg];
          state_next          = IDLE;
          ptr_next            = grant_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      deb_reg       <= '0;
      cnt_reg       <= '0;
      grant_reg     <= '0;
      ptr_reg       <= '0;
      evt_valid_reg <= 1'b0;
      evt_ch_reg    <= '0;
      evt_level_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      deb_reg       <= deb_next;
      cnt_reg       <= cnt_next;
      grant_reg     <= grant_next;
      ptr_reg       <= ptr_next;
      evt_valid_reg <= evt_valid_next;
      evt_ch_reg    <= evt_ch_next;
      evt_level_reg <= evt_level_next;
    end
  end

`ifdef DEBOUNCE_ABORT_CNT_EN
  logic [7:0] abort_cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      abort_cnt_reg <= '0;
    end else if (state_reg == COUNT && bounce && abort_cnt_reg != 8'hFF) begin
      abort_cnt_reg <= abort_cnt_reg + 1'b1;
    end
  end

  assign o_abort_cnt = abort_cnt_reg;
`endif

  assign o_sig_debounced = deb_reg;
  assign o_busy          = (state_reg != IDLE);
  assign o_grant_id      = grant_reg;
  assign evt.o_evt_valid = evt_valid_reg;
  assign evt.o_evt_ch    = evt_ch_reg;
  assign evt.o_evt_level = evt_level_reg;
endmodule

// File: doc/debounce_arbiter.md
Name: debounce_arbiter

Overview:
Multi-channel switch debouncer that shares a single stability counter among N_CH switch inputs.
- A round-robin arbiter grants the counter to one channel whose synchronised input differs from its debounced level.
- The FSM times the candidate level, then commits the new level or aborts if the input bounces back.
- Each accepted transition is reported as a change event on a valid/ready port to the panel/keypad controller.

Parameters:
N_CH, 4, number of switch channels (≥2)
N_BOUNCE, 3, stability window is 2^N_BOUNCE consecutive clk cycles

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
i_sig  input  N_CH  raw asynchronous switch inputs
o_sig_debounced  output  N_CH  debounced levels
o_busy  output  1  FSM not in IDLE
o_grant_id  output  $clog2(N_CH)  channel currently owning the counter
o_evt_valid  output  1  change event pending
o_evt_ch  output  $clog2(N_CH)  channel of pending event
o_evt_level  output  1  new debounced level of pending event
i_evt_ready  input  1  consumer accepts event when high with o_evt_valid
o_abort_cnt  output  8  only with DEBOUNCE_ABORT_CNT_EN

Behaviour:
- Reset values: all outputs 0; sync flops 0; counter 0; state IDLE; RR pointer 0.
- Reset is asynchronous and can occur anywhere, including mid-COUNT; it aborts immediately with no event.
- Synchronisation: per-channel 2-flop synchroniser giving sync[ch].
  - req[ch] = sync[ch] XOR o_sig_debounced[ch].
- Arbitration (IDLE only): round-robin search from ptr, i.e. last granted + 1 mod N_CH.
  - Any req: latch grant g, clear counter, go COUNT.
  - No req: stay IDLE.
- COUNT:
  - If sync[g] == o_sig_debounced[g] (bounce back): abort to IDLE, ptr <= g+1, no event.
  - Otherwise counter++.
  - The cycle the counter equals 2^N_BOUNCE-1 with input still stable: go COMMIT.
  - COUNT lasts exactly 2^N_BOUNCE cycles on success.
  - Other channels' reqs wait; their changes are not lost because req is level-based.
- COMMIT:
  - If !o_evt_valid or i_evt_ready: o_sig_debounced[g] <= ~o_sig_debounced[g].
  - Load the event with o_evt_ch=g and o_evt_level=new level; set o_evt_valid; go IDLE; ptr <= g+1.
  - Otherwise hold in COMMIT; the debounced level does not change until the slot frees.
- Event slot is single entry.
  - o_evt_valid stays high, with fields stable, until the cycle i_evt_ready is high.
  - Accept and reload in the same cycle is allowed: no bubble.
- Latency, uncontended with free slot: o_sig_debounced and o_evt_valid change on the (2^N_BOUNCE+4)th rising edge after the i_sig transition (12 for N_BOUNCE=3).
- Input high at reset release: treated as a change. It debounces to 1 and emits an event.
- o_grant_id holds its last value while IDLE.
- Counter width is N_BOUNCE bits and never wraps in COUNT.

Optional Feature:
DEBOUNCE_ABORT_CNT_EN
- Defined: port o_abort_cnt exists.
  - 8-bit counter increments on every COUNT abort, saturating at 255.
  - Cleared only by reset.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Clean press: N_CH=4, N_BOUNCE=3, ch1 0→1 stable, ready=1 -> o_sig_debounced=4'b0010 at edge 12; one event ch=1 level=1; o_busy high edges 3–12.
- Bounce: ch0 toggles every cycle for 20 cycles, then held 1 -> no event during toggling; exactly one event ch=0 level=1 after input settles; with macro, o_abort_cnt ≥1 and increments once per abort.
- Contention: ch0 and ch2 change in the same cycle, ptr=0 -> ch0 commits first; ch2 granted the cycle after ch0 COMMIT, commits 2^N_BOUNCE+2 cycles later; events in order ch0 then ch2.
- Round-robin fairness: after ch3 grant, simultaneous ch0 and ch3 changes -> ch0 granted before ch3.
- Backpressure: i_evt_ready=0, ch1 and ch2 change -> first event held stable; FSM holds in COMMIT for ch2 with its output unchanged; ready pulse for 1 cycle -> second event loaded next edge with no bubble.
- Reset mid-COUNT: rstn low at COUNT cycle 4 -> all outputs 0 immediately; no event; after release, input still high -> full debounce repeats and event emitted.
